// File: rtl/csrs_hub_if.sv
// Interfaces for csrs_hub: core-side request/response channel and broadcast CSR bank bus.
// The master modport is the initiator side of each channel.
interface csrs_req_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [1:0]      req_priv;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_illegal;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_priv,
    input  req_ready, rsp_valid, rsp_rdata, rsp_illegal
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_priv,
    output req_ready, rsp_valid, rsp_rdata, rsp_illegal
  );
endinterface

interface csrs_bank_if #(
  parameter int XLEN      = 32,
  parameter int NUM_BANKS = 4
);
  logic                      rden;
  logic [11:0]               raddr;
  logic [NUM_BANKS-1:0]      rvalid;
  logic [NUM_BANKS*XLEN-1:0] rdata;
  logic                      wren;
  logic [11:0]               waddr;
  logic [XLEN-1:0]           wdata;

  modport master (
    output rden, raddr, wren, waddr, wdata,
    input  rvalid, rdata
  );

  modport slave (
    input  rden, raddr, wren, waddr, wdata,
    output rvalid, rdata
  );
endinterface

// File: rtl/csrs_hub.sv
// csrs_hub: one-at-a-time atomic CSR read-modify-write hub in front of NUM_BANKS CSR banks.
// Optional build macro CSRS_HUB_COUNTER_EN adds an internal 64-bit cycle counter at 0xC00/0xC80.
module csrs_hub #(
  parameter int XLEN      = 32,
  parameter int NUM_BANKS = 4,
  parameter int TIMEOUT   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  csrs_req_if.slave   req,
  csrs_bank_if.master bank
);

  // state   | meaning
  // S_IDLE  | ready for a request, privilege/read-only check on accept
  // S_READ  | RDEN cycle, bank hits sampled
  // S_WAIT  | waiting for a bank hit, timer running
  // S_WRITE | WREN cycle with the modified value
  // S_RESP  | one-cycle response pulse
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_RESP} state_e;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CW = $clog2(NUM_BANKS + 2);

  state_e          state_q;
  logic [1:0]      op_q;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] old_q;
  logic [TW-1:0]   tmr_q;

  logic            rden_q;
  logic [11:0]     raddr_q;
  logic            wren_q;
  logic [11:0]     waddr_q;
  logic [XLEN-1:0] bwdata_q;
  logic            rsp_valid_q;
  logic [XLEN-1:0] rsp_rdata_q;
  logic            rsp_illegal_q;

  logic            priv_fault;
  logic            ro_fault;
  logic [CW-1:0]   hit_cnt;
  logic [XLEN-1:0] hit_data;
  logic [XLEN-1:0] bwdata_d;

  assign priv_fault = req.req_priv < req.req_addr[9:8];
  assign ro_fault   = (req.req_addr[11:10] == 2'b11) &&
                      ((req.req_op == 2'b01) || (req.req_op[1] && (req.req_wdata != '0)));

`ifdef CSRS_HUB_COUNTER_EN
  logic [63:0]     cyc_q;
  logic            cnt_hit;
  logic [XLEN-1:0] cnt_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) cyc_q <= '0;
    else       cyc_q <= cyc_q + 64'd1;
  end

  // The counter only answers in the RDEN cycle, like a zero-latency bank.
  always_comb begin
    cnt_hit  = 1'b0;
    cnt_data = '0;
    if (state_q == S_READ) begin
      if (addr_q == 12'hC00) begin
        cnt_hit  = 1'b1;
        cnt_data = cyc_q[XLEN-1:0];
      end else if ((XLEN == 32) && (addr_q == 12'hC80)) begin
        cnt_hit  = 1'b1;
        cnt_data = XLEN'(cyc_q[63:32]);
      end
    end
  end
`endif

  always_comb begin
    hit_cnt  = '0;
    hit_data = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bank.rvalid[i]) begin
        hit_cnt  = hit_cnt + CW'(1);
        hit_data = hit_data | bank.rdata[i*XLEN +: XLEN];
      end
    end
`ifdef CSRS_HUB_COUNTER_EN
    if (cnt_hit) begin
      hit_cnt  = hit_cnt + CW'(1);
      hit_data = hit_data | cnt_data;
    end
`endif
  end

  always_comb begin
    case (op_q)
      2'b01:   bwdata_d = wdata_q;
      2'b10:   bwdata_d = hit_data | wdata_q;
      default: bwdata_d = hit_data & ~wdata_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      old_q         <= '0;
      tmr_q         <= '0;
      rden_q        <= 1'b0;
      raddr_q       <= '0;
      wren_q        <= 1'b0;
      waddr_q       <= '0;
      bwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      // Strobes and their buses default low so buses read 0 whenever idle.
      rden_q        <= 1'b0;
      raddr_q       <= '0;
      wren_q        <= 1'b0;
      waddr_q       <= '0;
      bwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req.req_valid) begin
            op_q    <= req.req_op;
            addr_q  <= req.req_addr;
            wdata_q <= req.req_wdata;
            if (priv_fault || ro_fault) begin
              state_q       <= S_RESP;
              rsp_valid_q   <= 1'b1;
              rsp_illegal_q <= 1'b1;
            end else begin
              state_q <= S_READ;
              rden_q  <= 1'b1;
              raddr_q <= req.req_addr;
              tmr_q   <= TW'(TIMEOUT - 1);
            end
          end
        end
        S_READ, S_WAIT: begin
          if (hit_cnt > CW'(1)) begin
            state_q       <= S_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_illegal_q <= 1'b1;
          end else if (hit_cnt == CW'(1)) begin
            old_q <= hit_data;
            if (op_q == 2'b00) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= hit_data;
            end else begin
              state_q  <= S_WRITE;
              wren_q   <= 1'b1;
              waddr_q  <= addr_q;
              bwdata_q <= bwdata_d;
            end
          end else if (tmr_q == '0) begin
            state_q       <= S_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_illegal_q <= 1'b1;
          end else begin
            state_q <= S_WAIT;
            tmr_q   <= tmr_q - TW'(1);
          end
        end
        S_WRITE: begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= old_q;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Ready is masked by reset so it reads 0 while reset is held.
  assign req.req_ready   = (state_q == S_IDLE) && !rst_i;
  assign req.rsp_valid   = rsp_valid_q;
  assign req.rsp_rdata   = rsp_rdata_q;
  assign req.rsp_illegal = rsp_illegal_q;
  assign bank.rden       = rden_q;
  assign bank.raddr      = raddr_q;
  assign bank.wren       = wren_q;
  assign bank.waddr      = waddr_q;
  assign bank.wdata      = bwdata_q;

endmodule

// File: tb/tb_csrs_hub.sv
// Testbench for csrs_hub: directed vector table, reset sequences and randomized traffic
// checked against a cycle-count reference model.
module tb_csrs_hub;
  localparam int XLEN = 32;
  localparam int NB   = 4;
  localparam int TMO  = 4;
`ifdef CSRS_HUB_COUNTER_EN
  localparam logic [11:0] RC_ADDR = 12'hC03;
`else
  localparam logic [11:0] RC_ADDR = 12'hC00;
`endif

  typedef struct {
    logic [1:0]         op;
    logic [11:0]        addr;
    logic [XLEN-1:0]    wdata;
    logic [1:0]         priv;
    logic [NB-1:0]      mask;
    int                 delay;
    logic [NB*XLEN-1:0] data;
  } txn_t;

  typedef struct {
    int              rden_cyc;
    int              wren_cyc;
    logic [XLEN-1:0] wdata;
    int              rsp_cyc;
    logic            illegal;
    logic [XLEN-1:0] rdata;
  } exp_t;

  typedef struct {
    txn_t t;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  csrs_req_if  #(.XLEN(XLEN))                 req_if ();
  csrs_bank_if #(.XLEN(XLEN), .NUM_BANKS(NB)) bank_if ();

  csrs_hub #(.XLEN(XLEN), .NUM_BANKS(NB), .TIMEOUT(TMO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .req   (req_if.slave),
    .bank  (bank_if.master)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic [1:0] op, input logic [11:0] addr, input logic [XLEN-1:0] wd,
                              input logic [1:0] priv, input logic [NB-1:0] mask, input int dly,
                              input logic [XLEN-1:0] hv);
    txn_t t;
    t.op = op; t.addr = addr; t.wdata = wd; t.priv = priv; t.mask = mask; t.delay = dly;
    for (int i = 0; i < NB; i++)
      t.data[i*XLEN +: XLEN] = mask[i] ? hv : (32'hDEAD_0000 | XLEN'(i));
    return t;
  endfunction

  function automatic exp_t mke(input int rd, input int wr, input logic [XLEN-1:0] wd, input int rs,
                               input logic ill, input logic [XLEN-1:0] rdat);
    exp_t e;
    e.rden_cyc = rd; e.wren_cyc = wr; e.wdata = wd; e.rsp_cyc = rs; e.illegal = ill; e.rdata = rdat;
    return e;
  endfunction

  // Reference: cycle numbers are relative to the accept cycle T.
  function automatic exp_t model(input txn_t t);
    exp_t e;
    int hits;
    logic [XLEN-1:0] old;
    e = mke(0, 0, '0, 0, 1'b0, '0);
    old = '0;
    if (t.priv < t.addr[9:8] ||
        (t.addr[11:10] == 2'b11 && (t.op == 2'd1 || (t.op >= 2'd2 && t.wdata != '0)))) begin
      e.rsp_cyc = 1; e.illegal = 1'b1;
      return e;
    end
    e.rden_cyc = 1;
    hits = $countones(t.mask);
    if (hits == 0 || t.delay >= TMO) begin
      e.rsp_cyc = 1 + TMO; e.illegal = 1'b1;
    end else if (hits > 1) begin
      e.rsp_cyc = t.delay + 2; e.illegal = 1'b1;
    end else begin
      for (int i = 0; i < NB; i++) if (t.mask[i]) old = t.data[i*XLEN +: XLEN];
      e.rdata = old;
      case (t.op)
        2'd0: e.rsp_cyc = t.delay + 2;
        2'd1: begin e.wren_cyc = t.delay + 2; e.wdata = t.wdata;        e.rsp_cyc = t.delay + 3; end
        2'd2: begin e.wren_cyc = t.delay + 2; e.wdata = old | t.wdata;  e.rsp_cyc = t.delay + 3; end
        default: begin e.wren_cyc = t.delay + 2; e.wdata = old & ~t.wdata; e.rsp_cyc = t.delay + 3; end
      endcase
    end
    return e;
  endfunction

  task automatic run_txn(input string tag, input txn_t t, input exp_t e);
    int rden_n, rden_c, wren_n, wren_c, rsp_n, rsp_c;
    logic [11:0] raddr_s, waddr_s;
    logic [XLEN-1:0] wdata_s, rdata_s;
    logic ill_s, bz_bad;
    rden_n = 0; rden_c = 0; wren_n = 0; wren_c = 0; rsp_n = 0; rsp_c = 0;
    raddr_s = '0; waddr_s = '0; wdata_s = '0; rdata_s = '0; ill_s = 1'b0; bz_bad = 1'b0;
    @(negedge clk);
    check({tag, ".ready_idle"}, 64'(req_if.req_ready), 64'd1);
    req_if.req_valid = 1'b1;
    req_if.req_op    = t.op;
    req_if.req_addr  = t.addr;
    req_if.req_wdata = t.wdata;
    req_if.req_priv  = t.priv;
    bank_if.rvalid   = '0;
    bank_if.rdata    = t.data;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (bank_if.rden) begin rden_n++; rden_c = c; raddr_s = bank_if.raddr; end
      else if (bank_if.raddr != '0) bz_bad = 1'b1;
      if (bank_if.wren) begin wren_n++; wren_c = c; waddr_s = bank_if.waddr; wdata_s = bank_if.wdata; end
      else if (bank_if.waddr != '0 || bank_if.wdata != '0) bz_bad = 1'b1;
      if (req_if.rsp_valid) begin
        rsp_n++; rsp_c = c; rdata_s = req_if.rsp_rdata; ill_s = req_if.rsp_illegal;
        req_if.req_valid = 1'b0;
      end else if (req_if.rsp_rdata != '0 || req_if.rsp_illegal) bz_bad = 1'b1;
      if (c == 1) begin
        check({tag, ".ready_busy"}, 64'(req_if.req_ready), 64'd0);
        // Garbage on the request lines while busy must be neither accepted nor latched.
        req_if.req_op    = 2'($urandom);
        req_if.req_addr  = 12'($urandom);
        req_if.req_wdata = $urandom;
        req_if.req_priv  = 2'($urandom);
      end
      bank_if.rvalid = (c == 1 + t.delay) ? t.mask : '0;
      if (rsp_n > 0 && c > rsp_c) break;
    end
    bank_if.rvalid   = '0;
    req_if.req_valid = 1'b0;
    check({tag, ".rden_n"},   64'(rden_n), 64'(e.rden_cyc != 0 ? 1 : 0));
    check({tag, ".rden_cyc"}, 64'(rden_c), 64'(e.rden_cyc));
    if (e.rden_cyc != 0) check({tag, ".raddr"}, 64'(raddr_s), 64'(t.addr));
    check({tag, ".wren_n"},   64'(wren_n), 64'(e.wren_cyc != 0 ? 1 : 0));
    check({tag, ".wren_cyc"}, 64'(wren_c), 64'(e.wren_cyc));
    if (e.wren_cyc != 0) begin
      check({tag, ".waddr"}, 64'(waddr_s), 64'(t.addr));
      check({tag, ".wdata"}, 64'(wdata_s), 64'(e.wdata));
    end
    check({tag, ".rsp_n"},   64'(rsp_n), 64'd1);
    check({tag, ".rsp_cyc"}, 64'(rsp_c), 64'(e.rsp_cyc));
    check({tag, ".illegal"}, 64'(ill_s), 64'(e.illegal));
    check({tag, ".rdata"},   64'(rdata_s), 64'(e.rdata));
    check({tag, ".bus_zero"}, 64'(bz_bad), 64'd0);
  endtask

  vec_t vecs[14];

  initial begin
    txn_t t;
    int r;
    req_if.req_valid = 1'b0; req_if.req_op = '0; req_if.req_addr = '0;
    req_if.req_wdata = '0;   req_if.req_priv = '0;
    bank_if.rvalid = '0;     bank_if.rdata = '0;

    vecs[0]  = '{mk(2'd0, 12'h300, 32'h0,    2'd3, 4'b0010, 0, 32'h1800), mke(1, 0, 32'h0,    2, 1'b0, 32'h1800)};
    vecs[1]  = '{mk(2'd2, 12'h300, 32'h8,    2'd3, 4'b0010, 0, 32'h1800), mke(1, 2, 32'h1808, 3, 1'b0, 32'h1800)};
    vecs[2]  = '{mk(2'd0, 12'h300, 32'h0,    2'd0, 4'b0010, 0, 32'h1800), mke(0, 0, 32'h0,    1, 1'b1, 32'h0)};
    vecs[3]  = '{mk(2'd1, 12'hC00, 32'h5,    2'd3, 4'b0001, 0, 32'h1),    mke(0, 0, 32'h0,    1, 1'b1, 32'h0)};
    vecs[4]  = '{mk(2'd3, RC_ADDR, 32'h0,    2'd0, 4'b0001, 0, 32'hABCD), mke(1, 2, 32'hABCD, 3, 1'b0, 32'hABCD)};
    vecs[5]  = '{mk(2'd0, 12'h7C0, 32'h0,    2'd3, 4'b0000, 0, 32'h0),    mke(1, 0, 32'h0,    5, 1'b1, 32'h0)};
    vecs[6]  = '{mk(2'd1, 12'h340, 32'h9,    2'd3, 4'b0101, 0, 32'h77),   mke(1, 0, 32'h0,    2, 1'b1, 32'h0)};
    vecs[7]  = '{mk(2'd3, 12'h100, 32'hF0,   2'd1, 4'b1000, 2, 32'hFFFF), mke(1, 4, 32'hFF0F, 5, 1'b0, 32'hFFFF)};
    vecs[8]  = '{mk(2'd0, 12'h040, 32'h0,    2'd0, 4'b0100, 3, 32'h1234), mke(1, 0, 32'h0,    5, 1'b0, 32'h1234)};
    vecs[9]  = '{mk(2'd0, 12'h040, 32'h0,    2'd0, 4'b0100, 4, 32'h1234), mke(1, 0, 32'h0,    5, 1'b1, 32'h0)};
    vecs[10] = '{mk(2'd1, 12'h200, 32'hDEAD, 2'd2, 4'b0001, 1, 32'h55),   mke(1, 3, 32'hDEAD, 4, 1'b0, 32'h55)};
    vecs[11] = '{mk(2'd2, 12'hC01, 32'h0,    2'd3, 4'b0001, 0, 32'h77),   mke(1, 2, 32'h77,   3, 1'b0, 32'h77)};
    vecs[12] = '{mk(2'd2, 12'hC01, 32'h1,    2'd3, 4'b0001, 0, 32'h77),   mke(0, 0, 32'h0,    1, 1'b1, 32'h0)};
    vecs[13] = '{mk(2'd0, 12'h300, 32'h0,    2'd2, 4'b0001, 0, 32'h77),   mke(0, 0, 32'h0,    1, 1'b1, 32'h0)};

    // Power-on reset: everything low while held, ready on the first cycle after release.
    repeat (3) @(negedge clk);
    check("reset.strobes", 64'({bank_if.rden, bank_if.wren, req_if.rsp_valid, req_if.rsp_illegal}), 64'd0);
    check("reset.buses", 64'(|{bank_if.raddr, bank_if.waddr, bank_if.wdata, req_if.rsp_rdata}), 64'd0);
    check("reset.ready", 64'(req_if.req_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset.ready_after", 64'(req_if.req_ready), 64'd1);

    foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i].t, vecs[i].e);

    // Reset while a write is pending: the hit is sampled in READ, but reset wins that edge.
    @(negedge clk);
    req_if.req_valid = 1'b1; req_if.req_op = 2'd1; req_if.req_addr = 12'h300;
    req_if.req_wdata = 32'h1234; req_if.req_priv = 2'd3;
    bank_if.rdata = '0; bank_if.rdata[XLEN-1:0] = 32'h99;
    @(negedge clk);
    req_if.req_valid = 1'b0;
    check("midrst.rden", 64'(bank_if.rden), 64'd1);
    bank_if.rvalid = 4'b0001;
    rst = 1'b1;
    @(negedge clk);
    bank_if.rvalid = '0;
    check("midrst.quiet", 64'({bank_if.rden, bank_if.wren, req_if.rsp_valid}), 64'd0);
    check("midrst.ready_in_rst", 64'(req_if.req_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst.ready_after", 64'(req_if.req_ready), 64'd1);
    r = 0;
    repeat (4) begin
      @(negedge clk);
      if (bank_if.wren || req_if.rsp_valid) r++;
    end
    check("midrst.no_late_activity", 64'(r), 64'd0);

`ifdef CSRS_HUB_COUNTER_EN
    begin
      logic [XLEN-1:0] v0, v1;
      v0 = '0; v1 = '0;
      @(negedge clk);
      req_if.req_valid = 1'b1; req_if.req_op = 2'd0; req_if.req_addr = 12'hC00; req_if.req_priv = 2'd0;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        req_if.req_valid = 1'b0;
        if (req_if.rsp_valid) v0 = req_if.rsp_rdata;
      end
      req_if.req_valid = 1'b1;
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        req_if.req_valid = 1'b0;
        if (req_if.rsp_valid) v1 = req_if.rsp_rdata;
      end
      check("cnt.delta10", 64'(v1 - v0), 64'd10);
    end
`endif

    for (int n = 0; n < 150; n++) begin
      t.op    = 2'($urandom_range(0, 3));
      r       = $urandom_range(0, 5);
      t.addr  = (r == 0) ? 12'h300 : (r == 1) ? 12'hC05 : (r == 2) ? 12'h180 : 12'($urandom);
`ifdef CSRS_HUB_COUNTER_EN
      if (t.addr == 12'hC00 || t.addr == 12'hC80) t.addr = 12'hC01;
`endif
      t.wdata = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      t.priv  = 2'($urandom_range(0, 3));
      r       = $urandom_range(0, 9);
      t.mask  = (r < 6) ? NB'(1 << $urandom_range(0, NB - 1)) : (r == 6) ? '0 : NB'($urandom);
      t.delay = $urandom_range(0, 5);
      for (int i = 0; i < NB; i++) t.data[i*XLEN +: XLEN] = $urandom;
      run_txn($sformatf("rnd%0d", n), t, model(t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
